// File: rtl/laser_controller.sv
// Player laser: fire-edge arming, tick-driven upward flight, hit/miss cooldown,
// and a registered pixel-colour output for the laser sprite.
module laser_controller #(
  parameter int SCREEN_HEIGHT  = 480,
  parameter int SHIP_HEIGHT    = 30,
  parameter int V_OFFSET       = 10,
  parameter int LASER_STEP     = 8,
  parameter int LASER_WIDTH    = 2,
  parameter int LASER_LENGTH   = 12,
  parameter int COOLDOWN_TICKS = 4,
  parameter int LASER          = 6,
  parameter int NONE           = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fire,
  input  logic       hit,
  input  logic [9:0] gunPosition,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  output logic [9:0] laserX,
  output logic [9:0] laserY,
  output logic       active,
  output logic       shot_fired,
  output logic [2:0] color
);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

  localparam int               CNT_W    = $clog2(COOLDOWN_TICKS + 1);
  localparam logic [9:0]       SPAWN_Y  = 10'(V_OFFSET + SHIP_HEIGHT);
  localparam logic [10:0]      STEP     = 11'(LASER_STEP);
  localparam logic [10:0]      BOTTOM   = 11'(SCREEN_HEIGHT);
  localparam logic [10:0]      HALF_W   = 11'(LASER_WIDTH / 2);
  localparam logic [10:0]      LEN      = 11'(LASER_LENGTH);
  localparam logic [CNT_W-1:0] CD_LOAD  = CNT_W'(COOLDOWN_TICKS);
  localparam logic [CNT_W-1:0] CD_ONE   = CNT_W'(1);
  localparam logic [2:0]       C_LASER  = 3'(LASER);
  localparam logic [2:0]       C_NONE   = 3'(NONE);

  state_t           state, state_n;
  logic             pending, pending_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [9:0]       x_n, y_n;
  logic             shot_n;
  logic             fire_q;
  logic             fire_rise;
  logic [10:0]      y_step;
  logic             pix_on_p0;

  // Left edge of the sprite, clamped at column 0 when the laser hugs the border.
  function automatic logic [10:0] clamp_left(input logic [9:0] x);
    logic signed [11:0] d;
    d = $signed({2'b00, x}) - $signed({1'b0, HALF_W});
    return (d < 0) ? 11'd0 : d[10:0];
  endfunction

  function automatic logic in_sprite(input logic [9:0] lx, input logic [9:0] ly,
                                     input logic [9:0] h, input logic [9:0] v);
    logic [10:0] left, right, top, bot, hx, vy;
    left  = clamp_left(lx);
    right = {1'b0, lx} + HALF_W;
    top   = {1'b0, ly};
    bot   = top + LEN;
    hx    = {1'b0, h};
    vy    = {1'b0, v};
    return (hx >= left) && (hx < right) && (vy >= top) && (vy < bot);
  endfunction

  assign active    = (state == FLYING);
  assign fire_rise = fire & ~fire_q;
  assign y_step    = {1'b0, laserY} + STEP;

  always_comb begin
    state_n   = state;
    pending_n = pending;
    cnt_n     = cnt;
    x_n       = laserX;
    y_n       = laserY;
    shot_n    = 1'b0;
    case (state)
      IDLE: begin
        if (fire_rise) pending_n = 1'b1;
        if (pending && enable) begin
          pending_n = 1'b0;
          x_n       = gunPosition;
          y_n       = SPAWN_Y;
          shot_n    = 1'b1;
          state_n   = FLYING;
        end
      end
      FLYING: begin
        // A hit freezes the laser where it is, even on a movement tick.
        if (hit) begin
          state_n = COOLDOWN;
          cnt_n   = CD_LOAD;
        end else if (enable) begin
          if (y_step >= BOTTOM) begin
            state_n = COOLDOWN;
            cnt_n   = CD_LOAD;
          end else begin
            y_n = y_step[9:0];
          end
        end
      end
      COOLDOWN: begin
        if (enable) begin
          if (cnt <= CD_ONE) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CD_ONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      cnt        <= '0;
      laserX     <= '0;
      laserY     <= '0;
      shot_fired <= 1'b0;
      fire_q     <= 1'b0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      cnt        <= cnt_n;
      laserX     <= x_n;
      laserY     <= y_n;
      shot_fired <= shot_n;
      fire_q     <= fire;
    end
  end

  // Pixel stage p0 -> registered colour output.
  assign pix_on_p0 = active && in_sprite(laserX, laserY, hPos, vPos);

  always_ff @(posedge clk) begin
    if (reset) color <= C_NONE;
    else       color <= pix_on_p0 ? C_LASER : C_NONE;
  end

endmodule

// File: tb/tb_laser_controller.sv
// Directed bench for laser_controller: launch, flight/miss, hit, fire hold,
// pixel colour bounds and mid-flight reset.
module tb_laser_controller;

  logic       clk = 1'b0;
  logic       reset, enable, fire, hit;
  logic [9:0] gunPosition, hPos, vPos;
  logic [9:0] laserX, laserY;
  logic       active, shot_fired;
  logic [2:0] color;

  int tests = 0;
  int fails = 0;

  laser_controller dut (
    .clk(clk), .reset(reset), .enable(enable), .fire(fire), .hit(hit),
    .gunPosition(gunPosition), .hPos(hPos), .vPos(vPos),
    .laserX(laserX), .laserY(laserY), .active(active),
    .shot_fired(shot_fired), .color(color)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic en_pulse();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic fire_press();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 0; fire = 0; hit = 0;
    gunPosition = 10'd0; hPos = 10'd0; vPos = 10'd0;
    tick(); tick();
    reset = 1'b0;
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active got=%0b want=0", active); end
    tests++; if (laserX !== 10'd0) begin fails++; $display("FAIL reset_laserX got=%0d want=0", laserX); end
    tests++; if (laserY !== 10'd0) begin fails++; $display("FAIL reset_laserY got=%0d want=0", laserY); end
    tests++; if (shot_fired !== 1'b0) begin fails++; $display("FAIL reset_shot got=%0b want=0", shot_fired); end
    tests++; if (color !== 3'd7) begin fails++; $display("FAIL reset_color got=%0d want=7", color); end
  endtask

  task automatic test_launch();
    gunPosition = 10'd320;
    fire_press();
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL launch_wait_enable active got=%0b want=0", active); end
    en_pulse();
    tests++; if (shot_fired !== 1'b1) begin fails++; $display("FAIL launch_shot got=%0b want=1", shot_fired); end
    tests++; if (laserX !== 10'd320) begin fails++; $display("FAIL launch_x got=%0d want=320", laserX); end
    tests++; if (laserY !== 10'd40) begin fails++; $display("FAIL launch_y got=%0d want=40", laserY); end
    tests++; if (active !== 1'b1) begin fails++; $display("FAIL launch_active got=%0b want=1", active); end
    gunPosition = 10'd500;
    tick();
    tests++; if (shot_fired !== 1'b0) begin fails++; $display("FAIL launch_pulse_width got=%0b want=0", shot_fired); end
    tests++; if (laserX !== 10'd320) begin fails++; $display("FAIL launch_x_hold got=%0d want=320", laserX); end
  endtask

  task automatic test_color();
    hPos = 10'd319; vPos = 10'd45; tick();
    tests++; if (color !== 3'd6) begin fails++; $display("FAIL color_h319 got=%0d want=6", color); end
    hPos = 10'd320; tick();
    tests++; if (color !== 3'd6) begin fails++; $display("FAIL color_h320 got=%0d want=6", color); end
    hPos = 10'd321; tick();
    tests++; if (color !== 3'd7) begin fails++; $display("FAIL color_h321 got=%0d want=7", color); end
    hPos = 10'd318; tick();
    tests++; if (color !== 3'd7) begin fails++; $display("FAIL color_h318 got=%0d want=7", color); end
    hPos = 10'd320; vPos = 10'd51; tick();
    tests++; if (color !== 3'd6) begin fails++; $display("FAIL color_v51 got=%0d want=6", color); end
    vPos = 10'd52; tick();
    tests++; if (color !== 3'd7) begin fails++; $display("FAIL color_v52 got=%0d want=7", color); end
    vPos = 10'd39; tick();
    tests++; if (color !== 3'd7) begin fails++; $display("FAIL color_v39 got=%0d want=7", color); end
  endtask

  task automatic test_flight_miss();
    int shots = 0;
    for (int i = 0; i < 54; i++) begin
      en_pulse();
      if (shot_fired) shots++;
    end
    tests++; if (laserY !== 10'd472) begin fails++; $display("FAIL flight_y54 got=%0d want=472", laserY); end
    tests++; if (active !== 1'b1) begin fails++; $display("FAIL flight_active54 got=%0b want=1", active); end
    en_pulse();
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL miss_active got=%0b want=0", active); end
    tests++; if (laserY !== 10'd472) begin fails++; $display("FAIL miss_y_hold got=%0d want=472", laserY); end
    for (int i = 0; i < 3; i++) en_pulse();
    // A press during cooldown must be dropped, not queued.
    fire_press();
    en_pulse();
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL cooldown_4th active got=%0b want=0", active); end
    en_pulse();
    if (shot_fired) shots++;
    en_pulse();
    if (shot_fired) shots++;
    tests++; if (shots !== 0) begin fails++; $display("FAIL cooldown_press_discard shots got=%0d want=0", shots); end
    fire_press();
    en_pulse();
    tests++; if (shot_fired !== 1'b1) begin fails++; $display("FAIL relaunch_after_cooldown got=%0b want=1", shot_fired); end
    tests++; if (laserY !== 10'd40) begin fails++; $display("FAIL relaunch_y got=%0d want=40", laserY); end
    tests++; if (laserX !== 10'd500) begin fails++; $display("FAIL relaunch_x got=%0d want=500", laserX); end
  endtask

  task automatic test_hit();
    for (int i = 0; i < 3; i++) en_pulse();
    tests++; if (laserY !== 10'd64) begin fails++; $display("FAIL hit_pre_y got=%0d want=64", laserY); end
    hPos = 10'd500; vPos = 10'd66;
    hit = 1'b1; enable = 1'b1;
    tick();
    hit = 1'b0; enable = 1'b0;
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL hit_active got=%0b want=0", active); end
    tests++; if (laserY !== 10'd64) begin fails++; $display("FAIL hit_y_hold got=%0d want=64", laserY); end
    tests++; if (laserX !== 10'd500) begin fails++; $display("FAIL hit_x_hold got=%0d want=500", laserX); end
    tick();
    tests++; if (color !== 3'd7) begin fails++; $display("FAIL hit_color got=%0d want=7", color); end
    hit = 1'b1;
    for (int i = 0; i < 4; i++) en_pulse();
    hit = 1'b0;
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL hit_in_cooldown active got=%0b want=0", active); end
  endtask

  task automatic test_fire_hold();
    int shots = 0;
    gunPosition = 10'd0;
    fire = 1'b1;
    for (int i = 0; i < 100; i++) begin
      enable = 1'b1; tick(); if (shot_fired) shots++;
      enable = 1'b0; tick(); if (shot_fired) shots++;
    end
    tests++; if (shots !== 1) begin fails++; $display("FAIL hold_one_shot shots got=%0d want=1", shots); end
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL hold_idle active got=%0b want=0", active); end
    fire = 1'b0; tick();
    fire_press();
    en_pulse();
    tests++; if (shot_fired !== 1'b1) begin fails++; $display("FAIL hold_second_shot got=%0b want=1", shot_fired); end
    // Laser at column 0: clamped left bound keeps column 0 lit.
    hPos = 10'd0; vPos = 10'd40; tick();
    tests++; if (color !== 3'd6) begin fails++; $display("FAIL color_clamp_h0 got=%0d want=6", color); end
    hPos = 10'd1; tick();
    tests++; if (color !== 3'd7) begin fails++; $display("FAIL color_clamp_h1 got=%0d want=7", color); end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 7; i++) en_pulse();
    tests++; if (laserY !== 10'd96) begin fails++; $display("FAIL midflight_y got=%0d want=96", laserY); end
    hPos = 10'd0; vPos = 10'd100; tick();
    tests++; if (color !== 3'd6) begin fails++; $display("FAIL midflight_color got=%0d want=6", color); end
    reset = 1'b1; enable = 1'b1; fire = 1'b1;
    tick();
    reset = 1'b0; enable = 1'b0; fire = 1'b0;
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL rst_fly_active got=%0b want=0", active); end
    tests++; if (laserY !== 10'd0) begin fails++; $display("FAIL rst_fly_y got=%0d want=0", laserY); end
    tests++; if (color !== 3'd7) begin fails++; $display("FAIL rst_fly_color got=%0d want=7", color); end
    en_pulse();
    tests++; if (shot_fired !== 1'b0) begin fails++; $display("FAIL rst_no_pending got=%0b want=0", shot_fired); end
    gunPosition = 10'd200;
    fire_press();
    en_pulse();
    tests++; if (shot_fired !== 1'b1) begin fails++; $display("FAIL rst_relaunch_shot got=%0b want=1", shot_fired); end
    tests++; if (laserY !== 10'd40) begin fails++; $display("FAIL rst_relaunch_y got=%0d want=40", laserY); end
    tests++; if (laserX !== 10'd200) begin fails++; $display("FAIL rst_relaunch_x got=%0d want=200", laserX); end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_color();
    test_flight_miss();
    test_hit();
    test_fire_hold();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
